// File: rtl/prog_loader_ctrl.sv
// prog_loader_ctrl: UART byte-stream loader for the imem write port.
// Frame: SYNC, COUNT_HI, COUNT_LO, COUNT x 4 data bytes (LSB first), CHK.
module prog_loader_ctrl #(
  parameter int          Nloc      = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter int          TIMEOUT   = 1250000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_enable,
  output logic [31:0] wr_address,
  output logic [31:0] wr_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int WW = $clog2(Nloc + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CHECK
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [WW-1:0] widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] buf_q, buf_d;
  logic [7:0]  chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] cnt_new;

  assign wr_enable  = wr_en_q;
  assign wr_address = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_reset  = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

  assign cnt_new = {cnt_q[15:8], rx_data};

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      buf_q     <= '0;
      chk_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      bidx_q    <= bidx_d;
      buf_q     <= buf_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Frame parsing, word assembly, write issue and idle timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    buf_d     = buf_q;
    chk_d     = chk_q;
    tmo_d     = tmo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;

    if (state_q != IDLE) begin
      if (rx_valid) tmo_d = '0;
      else          tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == SYNC) begin
          state_d   = CNT_HI;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          chk_d     = '0;
          widx_d    = '0;
          bidx_d    = '0;
          tmo_d     = '0;
        end
      end
      CNT_HI: begin
        if (rx_valid) begin
          cnt_d[15:8] = rx_data;
          state_d     = CNT_LO;
        end
      end
      CNT_LO: begin
        if (rx_valid) begin
          cnt_d[7:0] = rx_data;
          if (cnt_new == 16'd0 || cnt_new > 16'(Nloc)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          chk_d  = chk_q ^ rx_data;
          bidx_d = bidx_q + 2'd1;
          unique case (bidx_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            2'd3: begin
              wr_en_d   = 1'b1;
              wr_data_d = {rx_data, buf_q};
              wr_addr_d = BASE_ADDR + (32'(widx_q) << 2);
              widx_d    = widx_q + WW'(1);
              if (32'(widx_q) + 32'd1 == 32'(cnt_q))
                state_d = CHECK;
            end
            default: ;
          endcase
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !rx_valid &&
        tmo_q == TW'(TIMEOUT - 1)) begin
      err_d   = 1'b1;
      state_d = IDLE;
      tmo_d   = '0;
    end

    busy_d = (state_d != IDLE);
  end

endmodule
